uart_rx_deserializer: RTL
=========================

// Module: uart_rx_deserializer
// PURPOSE
//  - Receive side of the UART link; mirrors the Tx serializer/FSM path.
//  - Oversamples rx_in, detects start bit, majority-votes each bit, shifts in
//    DATA_WIDTH bits LSB first, checks optional parity and stop bit, presents
//    a parallel byte with a 1-cycle valid strobe to the host-side logic.
//  - clk is the oversampling clock (prescale x baud).
// PARAMETERS
//  DATA_WIDTH   8   payload bits per frame
//  PRESCALE_W   6   width of prescale input / edge counter
// PORTS
//  clk         in   1           oversampling clock, rising edge
//  rst         in   1           asynchronous, active-low reset
//  rx_in       in   1           serial line, idle high, asynchronous to clk
//  prescale    in   PRESCALE_W  oversampling ratio: even, >=6
//  par_en      in   1           1 = parity bit present after data
//  par_typ     in   1           0 = even, 1 = odd parity
//  data_out    out  DATA_WIDTH  last good received word
//  data_valid  out  1           1-cycle pulse, data_out updated same cycle
//  par_err     out  1           1-cycle pulse, parity mismatch on frame
//  stop_err    out  1           1-cycle pulse, stop bit sampled 0
//  busy        out  1           high from start-bit detect to frame end
// BEHAVIOUR
//  - Reset: all outputs 0, FSM IDLE, counters 0, sync flops 1. Reset mid-frame
//    aborts frame; no strobe issued.
//  - rx_in passes a 2-flop synchronizer (reset value 1) before any use.
//  - prescale, par_en, par_typ captured on IDLE->START; changes mid-frame ignored.
//  - edge_cnt counts 0..prescale-1 per bit period; bit_cnt counts data bits.
//  - Sampling: samples at edge_cnt = P/2-1, P/2, P/2+1 (P = captured prescale);
//    bit value = majority of 3, valid from edge_cnt = P/2+2.
//  - FSM states: IDLE, START, DATA, PARITY, STOP.
//    IDLE:   synced rx = 0 -> START, edge_cnt=0, busy=1.
//    START:  at edge_cnt=P-1: voted bit 1 -> IDLE (glitch, no flags);
//            else -> DATA.
//    DATA:   at edge_cnt=P-1 shift voted bit into MSB, shift reg right
//            (first bit ends at [0]); after DATA_WIDTH bits -> PARITY if
//            par_en else STOP.
//    PARITY: expected = ^shift_reg XOR par_typ; mismatch latched internally.
//    STOP:   at edge_cnt=P-1: voted bit 0 -> stop_err pulse; parity mismatch
//            -> par_err pulse (both may pulse together); if neither, data_out
//            <= shift_reg and data_valid pulse. Then -> IDLE, busy=0.
//  - Errored frames never update data_out.
//  - Back-to-back frames: IDLE re-arms the cycle after STOP ends; a start edge
//    arriving during STOP is detected on that next cycle.
//  - edge_cnt wraps to 0 at P-1; bit_cnt wraps to 0 leaving DATA.
// STRUCTURE
//  - Shared package uart_pkg: state encoding (IDLE..STOP), PAR_EVEN/PAR_ODD
//    constants, DATA_WIDTH default; shared with Tx.
//  - Sub-module uart_rx_sampler: 3-sample majority vote + sample_done flag
//    given edge_cnt and prescale.
//  - Top: synchronizer, edge/bit counters, FSM, shift register, checks.
// TESTING
//  1. P=8, par_en=1 even, send 0xA5 (parity 0), stop 1 -> data_valid 1 cycle,
//     data_out=0xA5, no errors.
//  2. P=8, rx_in low 2 clk then high -> no busy past START, no strobes.
//  3. P=16, par_en=1 odd, send 0x3C with parity bit 0 -> par_err pulse,
//     data_out unchanged, no data_valid.
//  4. P=8, par_en=0, send 0x81 with stop bit 0 -> stop_err pulse,
//     data_out unchanged.
//  5. P=8, assert rst during 4th data bit of 0xFF -> outputs 0, IDLE; next
//     clean 0x12 frame -> data_out=0x12.
//  6. P=8, par_en=0, 0x00 then 0xFF back-to-back (no idle gap) -> two
//     data_valid pulses, data_out 0x00 then 0xFF.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding, parity selectors
// and the default payload width.
package uart_pkg;

  localparam int UART_DATA_WIDTH = 8;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_e;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Three-point mid-bit sampler: captures the line around the bit centre and
// reports the majority value once all three samples are in.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int PRESCALE_W = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_i,
  input  logic [PRESCALE_W-1:0] edge_cnt_i,
  input  logic [PRESCALE_W-1:0] prescale_i,
  output logic                  bit_o,
  output logic                  sample_done_o
);

  logic [PRESCALE_W-1:0] half;
  logic [2:0]            samples_q;

  assign half = prescale_i >> 1;

  // NOTE: clocked state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      samples_q <= 3'b111;
    end else begin
      if (edge_cnt_i == half - PRESCALE_W'(1)) samples_q[0] <= rx_i;
      if (edge_cnt_i == half)                  samples_q[1] <= rx_i;
      if (edge_cnt_i == half + PRESCALE_W'(1)) samples_q[2] <= rx_i;
    end
  end

  assign bit_o         = majority3(samples_q[0], samples_q[1], samples_q[2]);
  assign sample_done_o = (edge_cnt_i >= half + PRESCALE_W'(2));

endmodule

// File: rtl/uart_rx_deserializer.sv
// UART receiver: synchronises the serial line, walks start/data/parity/stop
// bit periods and presents each good word with a one-cycle valid strobe.
module uart_rx_deserializer
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = UART_DATA_WIDTH,
  parameter int PRESCALE_W = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_in,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  par_en,
  input  logic                  par_typ,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stop_err,
  output logic                  busy
);

  localparam int BIT_CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BIT_CNT_W-1:0] BIT_LAST = BIT_CNT_W'(DATA_WIDTH - 1);

  logic rx_meta_q, rx_sync_q;

  uart_state_e           state_q, state_d;
  logic [PRESCALE_W-1:0] edge_q, edge_d;
  logic [BIT_CNT_W-1:0]  bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [PRESCALE_W-1:0] prescale_q, prescale_d;
  logic                  par_en_q, par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic                  par_mis_q, par_mis_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  data_valid_q, data_valid_d;
  logic                  par_err_q, par_err_d;
  logic                  stop_err_q, stop_err_d;

  logic voted_bit, sample_done, bit_end;

  // rx_in is asynchronous; idle-high reset keeps the line from looking like a start bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= rx_in;
      rx_sync_q <= rx_meta_q;
    end
  end

  uart_rx_sampler #(.PRESCALE_W(PRESCALE_W)) u_sampler (
    .clk           (clk),
    .rst           (rst),
    .rx_i          (rx_sync_q),
    .edge_cnt_i    (edge_q),
    .prescale_i    (prescale_q),
    .bit_o         (voted_bit),
    .sample_done_o (sample_done)
  );

  assign bit_end = sample_done && (edge_q == prescale_q - PRESCALE_W'(1));

  always_comb begin
    // NOTE: every next-state signal gets its hold value first so no path infers a latch.
    state_d      = state_q;
    edge_d       = edge_q;
    bit_d        = bit_q;
    shift_d      = shift_q;
    prescale_d   = prescale_q;
    par_en_d     = par_en_q;
    par_typ_d    = par_typ_q;
    par_mis_d    = par_mis_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    par_err_d    = 1'b0;
    stop_err_d   = 1'b0;

    if (state_q != ST_IDLE) begin
      edge_d = bit_end ? '0 : edge_q + PRESCALE_W'(1);
    end

    unique case (state_q)
      ST_IDLE: begin
        edge_d = '0;
        bit_d  = '0;
        if (!rx_sync_q) begin
          state_d    = ST_START;
          prescale_d = prescale;
          par_en_d   = par_en;
          par_typ_d  = par_typ;
          par_mis_d  = 1'b0;
        end
      end
      ST_START: begin
        if (bit_end) state_d = voted_bit ? ST_IDLE : ST_DATA;
      end
      ST_DATA: begin
        if (bit_end) begin
          shift_d = {voted_bit, shift_q[DATA_WIDTH-1:1]};
          if (bit_q == BIT_LAST) begin
            bit_d   = '0;
            state_d = par_en_q ? ST_PARITY : ST_STOP;
          end else begin
            bit_d = bit_q + BIT_CNT_W'(1);
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          par_mis_d = voted_bit != ((^shift_q) ^ (par_typ_q == PAR_ODD));
          state_d   = ST_STOP;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          stop_err_d = ~voted_bit;
          par_err_d  = par_mis_q;
          if (voted_bit && !par_mis_q) begin
            data_out_d   = shift_q;
            data_valid_d = 1'b1;
          end
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      edge_q       <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      prescale_q   <= '0;
      par_en_q     <= 1'b0;
      par_typ_q    <= 1'b0;
      par_mis_q    <= 1'b0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      par_err_q    <= 1'b0;
      stop_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      edge_q       <= edge_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      prescale_q   <= prescale_d;
      par_en_q     <= par_en_d;
      par_typ_q    <= par_typ_d;
      par_mis_q    <= par_mis_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      par_err_q    <= par_err_d;
      stop_err_q   <= stop_err_d;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign par_err    = par_err_q;
  assign stop_err   = stop_err_q;
  assign busy       = (state_q != ST_IDLE);

endmodule
